dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port word-addressed data memory. It shares that memory between the CPU load/store unit (port 0) and a debug/loader port (port 1). Each accepted request becomes exactly one memory access. Write data reaches the memory on the access edge. Read data is registered and returned to the issuing port with a one-cycle valid pulse.

## Interface
- `ADDR_W`, default 32: byte-address width, passed unchanged to memory.
- `DATA_W`, default 32: data word width.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_req` / `m1_req`  in  1  request valid; held with fields stable until granted.
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr` / `m1_addr`  in  ADDR_W  byte address, word-aligned.
- `m0_wdata` / `m1_wdata`  in  DATA_W  write data.
- `m0_gnt` / `m1_gnt`  out  1  request accepted this cycle.
- `m0_rvalid` / `m1_rvalid`  out  1  one-cycle read-data-valid pulse.
- `m0_rdata` / `m1_rdata`  out  DATA_W  read data; holds its last value otherwise.
- `mem_read`  out  1  to memory `mem_read`.
- `mem_write`  out  1  to memory `mem_write`.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_write_data`  out  DATA_W  to memory `write_data`.
- `mem_read_data`  in  DATA_W  combinational read data from memory.

## Operation
- States: IDLE, ACCESS.
- IDLE, no request: stay in IDLE; all memory controls are 0.
- IDLE with any request: arbitrate and assert the winner's `gnt` combinationally in that cycle.
  - On the edge, latch the winner's id, `we`, `addr` and `wdata` into command registers, then go to ACCESS.
  - The loser gets no `gnt` and must keep `req` asserted.
- ACCESS: drive `mem_addr` and `mem_write_data` from the command registers, with `mem_write = we` and `mem_read = ~we`.
  - Write: memory updates on the ACCESS-exit edge.
  - Read: capture `mem_read_data` into the issuing port's `rdata` on the ACCESS-exit edge. Set that port's `rvalid` for the next cycle only.
  - Always return to IDLE. No grant is issued in ACCESS.
- Writes produce no `rvalid`.
- `rvalid` of the previous read may coincide with `gnt` of the next request.
- Default arbitration is fixed priority: port 0 wins every tie.
- Unselected memory data/address outputs are 0 in IDLE.
- Reset:
  - state IDLE; all `gnt`, `rvalid`, `mem_read` and `mem_write` 0; `rdata` 0; command registers 0.
  - `gnt`, `mem_read` and `mem_write` are gated by `~rst` in the same cycle. A reset during ACCESS therefore suppresses the pending write and any `rvalid`.

## Timing
- Cycle N: `req`=1 in IDLE, so `gnt`=1.
- N+1: ACCESS, memory strobes active.
- N+2: `rvalid`=1 with `rdata` valid for reads; a write is visible to a read issued at N+2.
- Throughput: one access per 2 cycles.
- A requester holding `req` after `gnt` is treated as a new request and is re-granted no earlier than N+2.
- `gnt` is combinational from `req` and state; everything else is registered.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin on ties.
  - A 1-bit `last` register is updated on each grant; on a tie the port not equal to `last` wins.
  - Reset value of `last` = 1, so port 0 wins the first tie.
  - With both ports requesting continuously, grants alternate 0,1,0,1.
- Not defined: fixed priority to port 0, and `last` is not present. Port 1 may starve while port 0 requests continuously; that is accepted behaviour.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - state encoding localparams `ST_IDLE`=1'b0 and `ST_ACCESS`=1'b1;
  - port id constants `PORT_CPU`=0 and `PORT_DBG`=1.
- One natural sub-module: `dmem_arb_pick`, the tie-break selector (`req0`, `req1`, `last` → `sel`, `any`), which holds the `DMEM_ARB_RR_EN` conditional.
- The FSM, command registers and response registers stay in the top module.

## Test plan
- Reset then idle: after `rst` deasserts, all outputs are 0 for 5 cycles.
- Port 0 write then read:
  - Write `addr` 0x10, `wdata` 0xDEADBEEF: `gnt` at N and `mem_write`=1 at N+1 only.
  - Read 0x10: `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF exactly 2 cycles after `gnt`; `m1_rvalid` stays 0.
- Simultaneous requests, port 0 read of 0x0 and port 1 read of 0x4:
  - Fixed priority: port 0 is granted first and port 1 two cycles later.
  - With `DMEM_ARB_RR_EN`: both held 8 cycles gives grant order 0,1,0,1.
- Port 1 write of 0x55 to 0x20 while port 0 holds a read of 0x20 issued the next cycle: port 0 reads back 0x55.
- Reset mid-access: assert `rst` during ACCESS of a write of 0xFFFFFFFF to 0x8.
  - `mem_write` stays 0 and memory is unchanged.
  - A later read of 0x8 returns the pre-test value.
- Back-to-back: port 0 holds `req` high across `gnt`.
  - Grants occur every 2 cycles.
  - `rvalid` pulses align with the next `gnt` and are never wider than 1 cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// requester port identifiers.
package dmem_arb_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Tie-break selector for the two-port data-memory arbiter.
// Optional macro DMEM_ARB_RR_EN: round-robin on ties using the 'last' input;
// otherwise port 0 (CPU) always wins a tie and 'last' does not exist.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DMEM_ARB_RR_EN
  input  logic last,
`endif
  output logic sel,
  output logic any
);

  // Pick the winning port from the two request lines.
  always_comb begin
    any = req0 | req1;
    sel = PORT_CPU;
`ifdef DMEM_ARB_RR_EN
    if (req0 && req1) begin
      sel = (last == PORT_CPU) ? PORT_DBG : PORT_CPU;
    end else if (req1) begin
      sel = PORT_DBG;
    end
`else
    if (!req0 && req1) begin
      sel = PORT_DBG;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port word memory.
// Port 0 is the CPU load/store unit, port 1 the debug/loader port.
// Each grant becomes one ACCESS cycle; reads return one cycle later.
// Optional macro DMEM_ARB_RR_EN: round-robin tie-break instead of fixed
// priority to port 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;

  logic              w_sel;
  logic              w_any;
  logic              w_grant;

  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  logic              r_cmd_port;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;

  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

`ifdef DMEM_ARB_RR_EN
  logic              r_last;
`endif

  dmem_arb_pick u_pick (
    .req0 (m0_req),
    .req1 (m1_req),
`ifdef DMEM_ARB_RR_EN
    .last (r_last),
`endif
    .sel  (w_sel),
    .any  (w_any)
  );

  // Fields of the winning request, captured into the command registers.
  assign w_win_we    = (w_sel == PORT_DBG) ? m1_we    : m0_we;
  assign w_win_addr  = (w_sel == PORT_DBG) ? m1_addr  : m0_addr;
  assign w_win_wdata = (w_sel == PORT_DBG) ? m1_wdata : m0_wdata;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, grants and memory strobes; grants and strobes are
  // suppressed in a reset cycle so an in-flight write never lands.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant        = 1'b0;
    m0_gnt         = 1'b0;
    m1_gnt         = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any && !rst) begin
          w_grant     = 1'b1;
          m0_gnt      = (w_sel == PORT_CPU);
          m1_gnt      = (w_sel == PORT_DBG);
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_addr       = r_cmd_addr;
        mem_write_data = r_cmd_wdata;
        mem_write      = ~rst & r_cmd_we;
        mem_read       = ~rst & ~r_cmd_we;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  // Command registers: latch the granted request for the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_port  <= PORT_CPU;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else if (w_grant) begin
      r_cmd_port  <= w_sel;
      r_cmd_we    <= w_win_we;
      r_cmd_addr  <= w_win_addr;
      r_cmd_wdata <= w_win_wdata;
    end
  end

  // Read response: capture memory data for the issuing port and pulse
  // its rvalid for exactly one cycle after the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (r_state == S_ACCESS && !r_cmd_we) begin
        if (r_cmd_port == PORT_CPU) begin
          r_rvalid0 <= 1'b1;
          r_rdata0  <= mem_read_data;
        end else begin
          r_rvalid1 <= 1'b1;
          r_rdata1  <= mem_read_data;
        end
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the most recent winner; reset to port 1 so port 0 wins the
  // first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= PORT_DBG;
    end else if (w_grant) begin
      r_last <= w_sel;
    end
  end
`endif

  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a
// randomized run checked cycle by cycle against a transaction-level model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-owned memory, 256 words, plus the model's view of it.
  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_init;

  always #5 clk = ~clk;

  assign mem_read_data = tb_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'hA500_0000 + 32'(i) * 32'd3;
    end else if (mem_write) begin
      tb_mem[mem_addr[9:2]] <= mem_write_data;
    end
  end

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // ---------------- transaction-level reference model ----------------
  int          cyc, next_free, acc_cyc, ret_cyc;
  logic        acc_valid, acc_port, acc_we, ret_valid, ret_port;
  logic [31:0] acc_addr, acc_wdata, exp_rd0, exp_rd1;
  logic        e_grant, e_win, e_gnt0, e_gnt1, e_mrd, e_mwr, e_rv0, e_rv1;
  logic [31:0] e_maddr, e_mwd;
`ifdef DMEM_ARB_RR_EN
  logic        mdl_last;
`endif

  task automatic model_init();
    cyc = 0; next_free = 0; acc_cyc = 0; ret_cyc = 0;
    acc_valid = 0; acc_port = 0; acc_we = 0; ret_valid = 0; ret_port = 0;
    acc_addr = 0; acc_wdata = 0; exp_rd0 = 0; exp_rd1 = 0;
`ifdef DMEM_ARB_RR_EN
    mdl_last = 1'b1;
`endif
  endtask

  // Expected outputs for the current cycle given the current inputs.
  task automatic model_eval();
    logic acc_now;
    e_win = (!m0_req && m1_req) ? 1'b1 : 1'b0;
`ifdef DMEM_ARB_RR_EN
    if (m0_req && m1_req) e_win = ~mdl_last;
`endif
    e_grant = !rst && (cyc >= next_free) && (m0_req || m1_req);
    e_gnt0  = e_grant && !e_win;
    e_gnt1  = e_grant && e_win;
    acc_now = acc_valid && (acc_cyc == cyc);
    e_mwr   = !rst && acc_now && acc_we;
    e_mrd   = !rst && acc_now && !acc_we;
    e_maddr = acc_now ? acc_addr : 32'h0;
    e_mwd   = acc_now ? acc_wdata : 32'h0;
    e_rv0   = ret_valid && (ret_cyc == cyc) && !ret_port;
    e_rv1   = ret_valid && (ret_cyc == cyc) && ret_port;
  endtask

  // Advance the model across the clock edge ending the current cycle.
  task automatic model_commit();
    if (rst) begin
      acc_valid = 0; ret_valid = 0; exp_rd0 = 0; exp_rd1 = 0;
      next_free = cyc + 1;
`ifdef DMEM_ARB_RR_EN
      mdl_last = 1'b1;
`endif
    end else begin
      if (ret_valid && ret_cyc <= cyc) ret_valid = 0;
      if (acc_valid && acc_cyc == cyc) begin
        if (acc_we) ref_mem[acc_addr[9:2]] = acc_wdata;
        else begin
          ret_valid = 1; ret_cyc = cyc + 1; ret_port = acc_port;
          if (acc_port) exp_rd1 = ref_mem[acc_addr[9:2]];
          else          exp_rd0 = ref_mem[acc_addr[9:2]];
        end
        acc_valid = 0;
      end
      if (e_grant) begin
        acc_valid = 1; acc_cyc = cyc + 1; acc_port = e_win;
        acc_we    = e_win ? m1_we    : m0_we;
        acc_addr  = e_win ? m1_addr  : m0_addr;
        acc_wdata = e_win ? m1_wdata : m0_wdata;
        next_free = cyc + 2;
`ifdef DMEM_ARB_RR_EN
        mdl_last = e_win;
`endif
      end
    end
    cyc++;
  endtask

  // ---------------------------- scenarios ----------------------------
  task automatic test_reset();
    rst = 1; mem_init = 1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1 m0_req = 1; mem_init = 0;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_gate_gnt: got %b want 0", m0_gnt); end
    @(posedge clk); #1 rst = 0; m0_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write} !== 6'b0 ||
          m0_rdata !== 0 || m1_rdata !== 0 || mem_addr !== 0 || mem_write_data !== 0) begin
        n_errors++;
        $display("FAIL idle_outputs cyc%0d: ctl=%b rd0=%h rd1=%h addr=%h wd=%h want all 0", i,
                 {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write}, m0_rdata, m1_rdata, mem_addr, mem_write_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_errors++; $display("FAIL wr_gnt: got %b%b want 10", m0_gnt, m1_gnt); end
    n_checks++; if (mem_write !== 1'b0) begin n_errors++; $display("FAIL wr_early_strobe: got %b want 0", mem_write); end
    @(posedge clk); #1 m0_req = 0;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_errors++; $display("FAIL wr_strobe: got w=%b r=%b want w=1 r=0", mem_write, mem_read); end
    n_checks++; if (mem_addr !== 32'h10 || mem_write_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_bus: got %h/%h want 10/deadbeef", mem_addr, mem_write_data); end
    n_checks++; if (m0_gnt !== 1'b0) begin n_errors++; $display("FAIL wr_no_gnt_access: got %b want 0", m0_gnt); end
    @(posedge clk); #1;
    ref_mem[4] = 32'hDEADBEEF;
    m0_req = 1; m0_we = 0;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b0 || m0_rvalid !== 1'b0) begin n_errors++; $display("FAIL wr_after: got w=%b rv=%b want 0 0", mem_write, m0_rvalid); end
    n_checks++; if (m0_gnt !== 1'b1) begin n_errors++; $display("FAIL rd_gnt: got %b want 1", m0_gnt); end
    @(posedge clk); #1 m0_req = 0;
    @(negedge clk);
    n_checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h10) begin n_errors++; $display("FAIL rd_strobe: got r=%b a=%h want 1/10", mem_read, mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_data: got rv=%b d=%h want 1/deadbeef", m0_rvalid, m0_rdata); end
    n_checks++; if (m1_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd_wrong_port: got %b want 0", m1_rvalid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_hold: got rv=%b d=%h want 0/deadbeef", m0_rvalid, m0_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    logic eg0, eg1, erv0, erv1;
    bit   rr;
`ifdef DMEM_ARB_RR_EN
    rr = 1;
`else
    rr = 0;
`endif
    m0_req = 1; m0_we = 0; m0_addr = 32'h0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h4;
    for (int c = 0; c < 8; c++) begin
      eg0  = rr ? (c == 0 || c == 4) : (c == 0);
      eg1  = (c == 2) || (rr && c == 6);
      erv0 = (c == 2) || (rr && c == 6);
      erv1 = (c == 4);
      @(negedge clk);
      n_checks++; if (m0_gnt !== eg0 || m1_gnt !== eg1) begin n_errors++; $display("FAIL tie_gnt c%0d: got %b%b want %b%b", c, m0_gnt, m1_gnt, eg0, eg1); end
      n_checks++; if (m0_rvalid !== erv0 || m1_rvalid !== erv1) begin n_errors++; $display("FAIL tie_rvalid c%0d: got %b%b want %b%b", c, m0_rvalid, m1_rvalid, erv0, erv1); end
      if (erv0) begin n_checks++; if (m0_rdata !== ref_mem[0]) begin n_errors++; $display("FAIL tie_rd0: got %h want %h", m0_rdata, ref_mem[0]); end end
      if (erv1) begin n_checks++; if (m1_rdata !== ref_mem[1]) begin n_errors++; $display("FAIL tie_rd1: got %h want %h", m1_rdata, ref_mem[1]); end end
      @(posedge clk); #1;
      if (!rr && eg0) m0_req = 0;
      if (!rr && eg1) m1_req = 0;
    end
    m0_req = 0; m1_req = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_wr_then_rd();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55;
    @(negedge clk);
    n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_errors++; $display("FAIL p1wr_gnt: got %b%b want 01", m0_gnt, m1_gnt); end
    @(posedge clk); #1 m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b0 || mem_write !== 1'b1) begin n_errors++; $display("FAIL p1wr_access: got g=%b w=%b want 0 1", m0_gnt, mem_write); end
    @(posedge clk); #1 ref_mem[8] = 32'h55;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b1) begin n_errors++; $display("FAIL p0rd_gnt: got %b want 1", m0_gnt); end
    @(posedge clk); #1 m0_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h55) begin n_errors++; $display("FAIL p0rd_data: got rv=%b d=%h want 1/55", m0_rvalid, m0_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] pre;
    pre = ref_mem[2];
    m0_req = 1; m0_we = 1; m0_addr = 32'h8; m0_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b1) begin n_errors++; $display("FAIL rma_gnt: got %b want 1", m0_gnt); end
    @(posedge clk); #1 m0_req = 0; rst = 1;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin n_errors++; $display("FAIL rma_strobe: got w=%b r=%b want 0 0", mem_write, mem_read); end
    @(posedge clk); #1 rst = 0; m0_req = 1; m0_we = 0;
    @(negedge clk);
    n_checks++; if (tb_mem[2] !== pre) begin n_errors++; $display("FAIL rma_mem: got %h want %h", tb_mem[2], pre); end
    n_checks++; if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b0) begin n_errors++; $display("FAIL rma_regnt: got g=%b rv=%b want 1 0", m0_gnt, m0_rvalid); end
    @(posedge clk); #1 m0_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== pre) begin n_errors++; $display("FAIL rma_read: got rv=%b d=%h want 1/%h", m0_rvalid, m0_rdata, pre); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic eg, erv;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      eg  = (c % 2 == 0);
      erv = (c >= 2) && (c % 2 == 0);
      @(negedge clk);
      n_checks++; if (m0_gnt !== eg) begin n_errors++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, m0_gnt, eg); end
      n_checks++; if (m0_rvalid !== erv) begin n_errors++; $display("FAIL b2b_rvalid c%0d: got %b want %b", c, m0_rvalid, erv); end
      n_checks++; if (mem_read !== !eg) begin n_errors++; $display("FAIL b2b_mem_read c%0d: got %b want %b", c, mem_read, !eg); end
      if (erv) begin n_checks++; if (m0_rdata !== ref_mem[4]) begin n_errors++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, m0_rdata, ref_mem[4]); end end
      @(posedge clk); #1;
    end
    m0_req = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random(input int ncyc);
    logic g0, g1;
    rst = 1; m0_req = 0; m1_req = 0;
    @(posedge clk); #1 rst = 0;
    model_init();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      model_eval();
      n_checks++; if (m0_gnt !== e_gnt0) begin n_errors++; $display("FAIL rnd_gnt0 c%0d: got %b want %b", c, m0_gnt, e_gnt0); end
      n_checks++; if (m1_gnt !== e_gnt1) begin n_errors++; $display("FAIL rnd_gnt1 c%0d: got %b want %b", c, m1_gnt, e_gnt1); end
      n_checks++; if (m0_rvalid !== e_rv0) begin n_errors++; $display("FAIL rnd_rv0 c%0d: got %b want %b", c, m0_rvalid, e_rv0); end
      n_checks++; if (m1_rvalid !== e_rv1) begin n_errors++; $display("FAIL rnd_rv1 c%0d: got %b want %b", c, m1_rvalid, e_rv1); end
      n_checks++; if (m0_rdata !== exp_rd0) begin n_errors++; $display("FAIL rnd_rd0 c%0d: got %h want %h", c, m0_rdata, exp_rd0); end
      n_checks++; if (m1_rdata !== exp_rd1) begin n_errors++; $display("FAIL rnd_rd1 c%0d: got %h want %h", c, m1_rdata, exp_rd1); end
      n_checks++; if (mem_read !== e_mrd) begin n_errors++; $display("FAIL rnd_mrd c%0d: got %b want %b", c, mem_read, e_mrd); end
      n_checks++; if (mem_write !== e_mwr) begin n_errors++; $display("FAIL rnd_mwr c%0d: got %b want %b", c, mem_write, e_mwr); end
      n_checks++; if (mem_addr !== e_maddr) begin n_errors++; $display("FAIL rnd_maddr c%0d: got %h want %h", c, mem_addr, e_maddr); end
      n_checks++; if (mem_write_data !== e_mwd) begin n_errors++; $display("FAIL rnd_mwd c%0d: got %h want %h", c, mem_write_data, e_mwd); end
      g0 = e_gnt0; g1 = e_gnt1;
      model_commit();
      @(posedge clk); #1;
      rst = ($urandom_range(0, 63) == 0);
      if (g0) begin
        if ($urandom_range(0, 1) == 1) begin
          m0_we = 1'($urandom_range(0, 1)); m0_addr = 32'($urandom_range(0, 15)) << 2; m0_wdata = $urandom;
        end else m0_req = 0;
      end else if (!m0_req && $urandom_range(0, 2) == 0) begin
        m0_req = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = 32'($urandom_range(0, 15)) << 2; m0_wdata = $urandom;
      end
      if (g1) begin
        if ($urandom_range(0, 1) == 1) begin
          m1_we = 1'($urandom_range(0, 1)); m1_addr = 32'($urandom_range(0, 15)) << 2; m1_wdata = $urandom;
        end else m1_req = 0;
      end else if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = 32'($urandom_range(0, 15)) << 2; m1_wdata = $urandom;
      end
    end
    rst = 0; m0_req = 0; m1_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 + 32'(i) * 32'd3;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_wr_then_rd();
    test_reset_mid_access();
    test_back_to_back();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
